// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and helpers for the serial adder arbiter slice.
//   sa_arb_state_t : controller state encoding (3-bit)
//   cnt_width()    : width of a counter that must hold 0..width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } sa_arb_state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_arbiter_rr.sv
// -----------------------------------------------------------------------------
// sa_rr_arbiter
// Picks one requester out of NUM_REQ. Round-robin by default: the search
// starts at the pointer and wraps, and the pointer moves to winner+1 when
// upd is high. With SA_ARB_FIXED_PRIO_EN defined the lowest index always
// wins and no pointer register exists.
// Ports:
//   clk_i, resetn_i : clock, synchronous active-low reset
//   req             : request vector
//   upd             : commit the current grant (advance pointer)
//   gnt             : one-hot grant (combinational)
//   idx             : index of the granted requester
// Macro: SA_ARB_FIXED_PRIO_EN
// -----------------------------------------------------------------------------
module sa_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic [NUM_REQ-1:0] req,
   input  logic               upd,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx
);

`ifdef SA_ARB_FIXED_PRIO_EN

   logic unused_ctrl;
   assign unused_ctrl = ^{clk_i, resetn_i, upd};

   // Scan high to low so the lowest set index is the last one written.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = ID_W'(i);
         end
      end
   end

`else

   logic [ID_W-1:0] ptr_q;
   logic            found;
   int              j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = ID_W'(j);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         ptr_q <= '0;
      end else if (upd && (|req)) begin
         ptr_q <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

`endif

endmodule

// File: rtl/serial_adder_arbiter.sv
// -----------------------------------------------------------------------------
// serial_adder_arbiter
// Shares one serial adder datapath between NUM_REQ requesters. A winner is
// picked in IDLE, its operands latched, and the datapath is walked through
// clear (IDLE), load, WIDTH shift cycles and a capture cycle. The parallel
// sum/carry is then offered with the requester ID on a valid/ready port.
// Ports:
//   clk_i, resetn_i        : clock, synchronous active-low reset
//   req_i [NUM_REQ]        : request levels
//   a_i, b_i               : operands, slice k belongs to requester k
//   gnt_o [NUM_REQ]        : one-hot single-cycle grant (LOAD cycle)
//   sa_reset_o/load/enable : datapath control (Moore decodes)
//   sa_a_o, sa_b_o         : latched operands to datapath
//   sa_sum_i, sa_cout_i    : datapath result
//   rsp_valid_o/ready_i    : response handshake
//   rsp_id_o/sum_o/cout_o  : response payload
// Macro: SA_ARB_FIXED_PRIO_EN (fixed priority arbitration, in sa_rr_arbiter)
// -----------------------------------------------------------------------------
module serial_adder_arbiter
   import serial_adder_pkg::*;
#(
   parameter  int WIDTH   = 8,
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk_i,
   input  logic                     resetn_i,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*WIDTH-1:0] a_i,
   input  logic [NUM_REQ*WIDTH-1:0] b_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic                     sa_reset_o,
   output logic                     sa_load_o,
   output logic                     sa_enable_o,
   output logic [WIDTH-1:0]         sa_a_o,
   output logic [WIDTH-1:0]         sa_b_o,
   input  logic [WIDTH-1:0]         sa_sum_i,
   input  logic                     sa_cout_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [ID_W-1:0]          rsp_id_o,
   output logic [WIDTH-1:0]         rsp_sum_o,
   output logic                     rsp_cout_o
);

   localparam int CNT_W = cnt_width(WIDTH);

   sa_arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic [ID_W-1:0]      arb_idx;
   logic                 arb_upd;
   logic                 last_shift;

   logic [NUM_REQ-1:0]   gnt_p0;
   logic [WIDTH-1:0]     a_p0, b_p0;
   logic [ID_W-1:0]      id_p0;
   logic [WIDTH-1:0]     sum_p1;
   logic                 cout_p1;

   assign arb_upd    = (state_q == IDLE) && (|req_i);
   assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

   sa_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .req      (req_i),
      .upd      (arb_upd),
      .gnt      (arb_gnt),
      .idx      (arb_idx)
   );

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sa_reset_o  = 1'b0;
      sa_load_o   = 1'b0;
      sa_enable_o = 1'b0;
      rsp_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            sa_reset_o = 1'b1;
            if (|req_i) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            sa_load_o = 1'b1;
            state_d   = SHIFT;
         end
         SHIFT: begin
            sa_enable_o = 1'b1;
            if (last_shift) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Grant stage: operands and ID captured on the IDLE->LOAD edge
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         gnt_p0 <= '0;
         a_p0   <= '0;
         b_p0   <= '0;
         id_p0  <= '0;
      end else begin
         gnt_p0 <= arb_upd ? arb_gnt : '0;
         if (arb_upd) begin
            a_p0  <= a_i[int'(arb_idx)*WIDTH +: WIDTH];
            b_p0  <= b_i[int'(arb_idx)*WIDTH +: WIDTH];
            id_p0 <= arb_idx;
         end
      end
   end

   // Shift counter sits at 0 outside SHIFT so every operation starts clean
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         cnt_q <= '0;
      end else if ((state_q == SHIFT) && !last_shift) begin
         cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q <= '0;
      end
   end

   // Capture stage: datapath result held until the response is accepted
   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         sum_p1  <= '0;
         cout_p1 <= 1'b0;
      end else if (state_q == CAPTURE) begin
         sum_p1  <= sa_sum_i;
         cout_p1 <= sa_cout_i;
      end
   end

   assign gnt_o      = gnt_p0;
   assign sa_a_o     = a_p0;
   assign sa_b_o     = b_p0;
   assign rsp_id_o   = id_p0;
   assign rsp_sum_o  = sum_p1;
   assign rsp_cout_o = cout_p1;

endmodule

// File: doc/serial_adder_arbiter.md
Name: serial_adder_arbiter

Overview:
- Shares one serial adder datapath between NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the adder through reset, load and WIDTH shift cycles, captures the parallel sum/carry, and returns it with the requester ID over a valid/ready response port.
- Sits between client logic and the serial adder datapath, replacing the single-user start/done controller.

Parameters:
- WIDTH, 8: operand and sum width in bits; also the number of shift cycles.
- NUM_REQ, 4: number of requesters (>=2).
- ID_W, $clog2(NUM_REQ): localparam; requester ID width.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- resetn_i  in  1  synchronous active-low reset.
- req_i  in  NUM_REQ  per-requester request level.
- a_i  in  NUM_REQ*WIDTH  operand A; slice k belongs to requester k.
- b_i  in  NUM_REQ*WIDTH  operand B; slice k belongs to requester k.
- gnt_o  out  NUM_REQ  one-hot, single-cycle pulse when operands are captured.
- sa_reset_o  out  1  datapath clear.
- sa_load_o  out  1  datapath parallel load.
- sa_enable_o  out  1  datapath shift enable.
- sa_a_o  out  WIDTH  latched operand A to datapath.
- sa_b_o  out  WIDTH  latched operand B to datapath.
- sa_sum_i  in  WIDTH  datapath parallel sum.
- sa_cout_i  in  1  datapath final carry.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_id_o  out  ID_W  index of the requester served.
- rsp_sum_o  out  WIDTH  captured sum.
- rsp_cout_o  out  1  captured carry-out.

Behaviour:
- **Reset** (resetn_i low at a clock edge):
  - state=IDLE, rr pointer=0, shift count=0.
  - Operand and response registers cleared to 0.
  - gnt_o=0, rsp_valid_o=0, sa_load_o=0, sa_enable_o=0, sa_reset_o=1 (IDLE decode).
- **States:** IDLE, LOAD, SHIFT, CAPTURE, RESP. Outputs are Moore decodes of state, except gnt_o (registered pulse).
- **IDLE:**
  - sa_reset_o=1.
  - If any req_i bit is set: pick a winner, pulse gnt_o[winner] on the next cycle, latch a_i/b_i slice and ID, set pointer=winner+1 (mod NUM_REQ), go to LOAD.
  - Grants are issued only from IDLE.
- **LOAD:** sa_load_o=1 for exactly 1 cycle; sa_a_o/sa_b_o hold the latched operands from LOAD through SHIFT. Next state SHIFT.
- **SHIFT:**
  - sa_enable_o=1 for exactly WIDTH consecutive cycles.
  - Count runs 0..WIDTH-1 (width $clog2(WIDTH+1)).
  - When count==WIDTH-1, go to CAPTURE.
- **CAPTURE:** 1 cycle; register sa_sum_i and sa_cout_i into rsp_sum_o/rsp_cout_o; go to RESP.
- **RESP:**
  - rsp_valid_o=1; rsp_* held stable until rsp_valid_o && rsp_ready_i.
  - On that handshake, go to IDLE.
  - rsp_ready_i high before RESP has no effect.
- **Latency:**
  - Request seen in IDLE at edge T: gnt_o high in cycle T+1 (the LOAD cycle).
  - SHIFT occupies T+2..T+1+WIDTH, CAPTURE is T+2+WIDTH, rsp_valid_o rises at T+3+WIDTH.
  - Minimum issue interval is WIDTH+4 cycles, since each operation returns through one IDLE cycle.
- **Requester protocol:**
  - req_i is a level; a_i/b_i must be stable while req_i is high and ungranted.
  - Dropping req_i before grant is legal and has no effect.
  - req_i still high in the cycle after gnt_o is treated as a new request.
- **Round-robin:** search starts at the pointer index and wraps; a lone requester is granted every time.
- **Reset mid-operation:** abandons the operation, with no response and no further gnt_o. The datapath is cleared by sa_reset_o in IDLE.
- **Arithmetic:** sum is modulo 2^WIDTH; carry is reported in rsp_cout_o; no saturation.

Optional Feature:
- Macro: SA_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the rr pointer register is removed.
- Undefined (default): round-robin as above.
- Timing and handshakes are identical in both builds.

Decomposition:
- Package serial_adder_pkg holds:
  - sa_arb_state_t enum (IDLE, LOAD, SHIFT, CAPTURE, RESP; 3-bit).
  - Helper function for the count width.
- Sub-module sa_rr_arbiter, parameterised on NUM_REQ:
  - Inputs req and update-enable; outputs one-hot grant and index.
  - Owns the pointer register.
  - Contains the SA_ARB_FIXED_PRIO_EN switch.

Test Plan:
1. Single request: req_i=4'b0100, a=8'h3C, b=8'h0F; bench serial-adder model → gnt_o=4'b0100 for 1 cycle, sa_load_o 1 cycle, sa_enable_o 8 cycles, rsp_valid_o at T+11, rsp_sum_o=8'h4B, rsp_cout_o=0, rsp_id_o=2.
2. Overflow: a=8'hFF, b=8'h01 → rsp_sum_o=8'h00, rsp_cout_o=1; a=8'h80, b=8'h80 → 8'h00, cout=1.
3. Fairness: req_i=4'b1111 held and rsp_ready_i=1 → grant order 0,1,2,3,0, with WIDTH+4 cycles between grants. With SA_ARB_FIXED_PRIO_EN defined → always requester 0.
4. Backpressure: rsp_ready_i low for 5 cycles in RESP → rsp_valid_o and rsp_* stable, no gnt_o; one cycle after rsp_ready_i rises, state is IDLE.
5. Reset mid-SHIFT: resetn_i low for 1 cycle at count=3 → next cycle sa_enable_o=0, sa_reset_o=1, rsp_valid_o=0. A subsequent request from requester 3 is granted first (pointer=0, no other requests), and its result is correct.
6. Late drop: req_i[1] high then low before the IDLE cycle → no grant; a simultaneous req_i[0]|req_i[1] with pointer=1 → requester 1 granted.
